// File: rtl/pong_pkg.sv
// Shared pong definitions: scan FSM states and LED matrix geometry.
package pong_pkg;

    localparam int MATRIX_N     = 16;
    localparam int MATRIX_ROW_W = 4;
    localparam int MATRIX_BIT_W = $clog2(MATRIX_N);

    typedef enum logic [2:0] {
        FETCH,
        CAPTURE,
        SHIFT_COL,
        SHIFT_ROW,
        LATCH,
        DISPLAY
    } scan_state_t;

    // The row driver is a shift register; a single 1 enters at row 0 and walks down.
    function automatic logic row_seed(input logic [MATRIX_ROW_W-1:0] row);
        return (row == '0);
    endfunction

endpackage

// File: rtl/matrix_scanner_if.sv
// Frame-buffer read port between the matrix scanner (master) and the game frame buffer (slave).
interface matrix_scanner_if;
    import pong_pkg::*;

    logic                    fb_rd_en;
    logic [MATRIX_ROW_W-1:0] fb_row;
    logic [MATRIX_N-1:0]     fb_data;

    modport master (output fb_rd_en, output fb_row, input fb_data);
    modport slave  (input fb_rd_en, input fb_row, output fb_data);
endinterface

// File: rtl/matrix_col_shifter.sv
// 16-bit parallel-load, MSB-first PISO for the column driver.
module matrix_col_shifter
    import pong_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                shift,
    input  logic [MATRIX_N-1:0] data,
    output logic                msb_next
);
    logic [MATRIX_N-1:0] sr;

    // Look-ahead MSB so the caller can register CSDI on the same edge as the load/shift.
    assign msb_next = load  ? data[MATRIX_N-1] :
                      shift ? sr[MATRIX_N-2]   : sr[MATRIX_N-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= data;
        end else if (shift) begin
            sr <= {sr[MATRIX_N-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/matrix_scanner.sv
// Row-scan controller for the 16x16 LED matrix; `define MATRIX_DIM_EN adds the dim input
// (25% duty during the row dwell).
module matrix_scanner
    import pong_pkg::*;
#(
    parameter int SCREENTIMERWIDTH = 10
)
(
    input  logic             clk32mhz,
    input  logic             reset_n,
`ifdef MATRIX_DIM_EN
    input  logic             dim,
`endif
    matrix_scanner_if.master fb,
    output logic             CSDI,
    output logic             CCLK,
    output logic             RSDI,
    output logic             RCLK,
    output logic             LE,
    output logic             OEB,
    output logic             frame_done
);
    // state is the phase whose outputs get registered on the coming edge, so each
    // output is visible during the cycle the state names.
    scan_state_t                 state;
    logic [MATRIX_ROW_W-1:0]     row;
    logic [MATRIX_BIT_W-1:0]     bit_idx;
    logic                        phase;
    logic [SCREENTIMERWIDTH-1:0] dwell;
    logic                        col_load;
    logic                        col_shift;
    logic                        col_msb;
    logic                        dark;

    // The first column bit's edge also closes the CAPTURE cycle, where fb_data is valid.
    assign col_load  = (state == SHIFT_COL) && !phase && (&bit_idx);
    assign col_shift = (state == SHIFT_COL) && !phase && !(&bit_idx);

`ifdef MATRIX_DIM_EN
    logic dim_q;
    assign dark = dim_q && (dwell[SCREENTIMERWIDTH-1:SCREENTIMERWIDTH-2] != 2'b00);
`else
    assign dark = 1'b0;
`endif

    matrix_col_shifter u_col (
        .clk      (clk32mhz),
        .reset_n  (reset_n),
        .load     (col_load),
        .shift    (col_shift),
        .data     (fb.fb_data),
        .msb_next (col_msb)
    );

    always_ff @(posedge clk32mhz) begin
        if (!reset_n) begin
            state       <= FETCH;
            row         <= '0;
            bit_idx     <= '0;
            phase       <= 1'b0;
            dwell       <= '0;
            fb.fb_rd_en <= 1'b0;
            fb.fb_row   <= '0;
            CSDI        <= 1'b0;
            CCLK        <= 1'b0;
            RSDI        <= 1'b0;
            RCLK        <= 1'b0;
            LE          <= 1'b0;
            OEB         <= 1'b1;
            frame_done  <= 1'b0;
`ifdef MATRIX_DIM_EN
            dim_q       <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    fb.fb_rd_en <= 1'b1;
                    fb.fb_row   <= row;
                    OEB         <= 1'b1;
                    frame_done  <= 1'b0;
                    state       <= CAPTURE;
                end
                CAPTURE: begin
                    fb.fb_rd_en <= 1'b0;
                    bit_idx     <= '1;
                    phase       <= 1'b0;
                    state       <= SHIFT_COL;
                end
                SHIFT_COL: begin
                    if (!phase) begin
                        CCLK  <= 1'b0;
                        CSDI  <= col_msb;
                        phase <= 1'b1;
                    end else begin
                        CCLK  <= 1'b1;
                        phase <= 1'b0;
                        if (bit_idx == '0) state <= SHIFT_ROW;
                        else               bit_idx <= bit_idx - 1'b1;
                    end
                end
                SHIFT_ROW: begin
                    CCLK <= 1'b0;
                    CSDI <= 1'b0;
                    RSDI <= row_seed(row);
                    if (!phase) begin
                        RCLK  <= 1'b0;
                        phase <= 1'b1;
                    end else begin
                        RCLK  <= 1'b1;
                        phase <= 1'b0;
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    RCLK  <= 1'b0;
                    RSDI  <= 1'b0;
                    LE    <= 1'b1;
                    dwell <= '0;
`ifdef MATRIX_DIM_EN
                    dim_q <= dim;
`endif
                    state <= DISPLAY;
                end
                DISPLAY: begin
                    LE    <= 1'b0;
                    OEB   <= dark;
                    dwell <= dwell + 1'b1;
                    if (&dwell) begin
                        frame_done <= &row;
                        row        <= row + 1'b1;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_scanner.sv
// Randomized bench for matrix_scanner: outputs are predicted from the position within the
// row/frame period; covers the MATRIX_DIM_EN build as well.
module tb_matrix_scanner;
    import pong_pkg::*;

    localparam int W     = 2;
    localparam int P     = 37 + (1 << W);
    localparam int FRAME = 16 * P;

    logic clk32mhz = 1'b0;
    logic reset_n;
    logic dim_sel;
    logic CSDI, CCLK, RSDI, RCLK, LE, OEB, frame_done;

    always #5 clk32mhz = ~clk32mhz;

    matrix_scanner_if fbi ();

`ifdef MATRIX_DIM_EN
    localparam bit HAS_DIM = 1'b1;
    logic dim;
    assign dim = dim_sel;
`else
    localparam bit HAS_DIM = 1'b0;
`endif

    matrix_scanner #(.SCREENTIMERWIDTH(W)) dut (
        .clk32mhz   (clk32mhz),
        .reset_n    (reset_n),
`ifdef MATRIX_DIM_EN
        .dim        (dim),
`endif
        .fb         (fbi.master),
        .CSDI       (CSDI),
        .CCLK       (CCLK),
        .RSDI       (RSDI),
        .RCLK       (RCLK),
        .LE         (LE),
        .OEB        (OEB),
        .frame_done (frame_done)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cur_t    = 0;
    int          cyc      = 0;
    int          last_fd  = -1;
    int          ncclk    = 0;
    logic        cclk_prev = 1'b0;
    logic [15:0] sh       = '0;
    logic [15:0] mem [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, cur_t, got, exp);
        end
    endtask

    // Synchronous-read frame buffer: data for a strobe seen in cycle N is presented in
    // cycle N+1; every other cycle carries junk the scanner must ignore.
    initial begin
        logic                    rd;
        logic [MATRIX_ROW_W-1:0] rw;
        fbi.fb_data = '0;
        forever begin
            @(negedge clk32mhz);
            rd = fbi.fb_rd_en;
            rw = fbi.fb_row;
            @(posedge clk32mhz);
            #1;
            fbi.fb_data = rd ? mem[rw] : 16'($urandom);
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        mem[3] = 16'hA5C3;
    endtask

    task automatic check_cycle(input int t);
        int   r, o, on_len;
        logic dim_eff;
        r       = (t / P) % 16;
        o       = t % P;
        dim_eff = HAS_DIM ? dim_sel : 1'b0;
        on_len  = dim_eff ? (1 << (W - 2)) : (1 << W);
        cur_t   = t;

        chk("rd_en",  32'(fbi.fb_rd_en), 32'(o == 0));
        chk("fb_row", 32'(fbi.fb_row),   r);
        chk("cclk",   32'(CCLK), 32'(o >= 2 && o < 34 && (o % 2) == 1));
        if (o >= 2 && o < 34) chk("csdi", 32'(CSDI), 32'(mem[r][15 - (o - 2) / 2]));
        chk("rclk",   32'(RCLK), 32'(o == 35));
        if (o == 34 || o == 35) chk("rsdi", 32'(RSDI), 32'(r == 0));
        chk("le",     32'(LE),   32'(o == 36));
        chk("oeb",    32'(OEB),  32'(!(o >= 37 && o < 37 + on_len)));
        chk("fdone",  32'(frame_done), 32'(o == P - 1 && r == 15));
        chk("blank",  32'((LE | CCLK | RCLK) & ~OEB), 0);

        // Column bits as the driver would see them on CCLK rising edges.
        if (o == 0) begin
            ncclk = 0;
            sh    = '0;
        end
        if (CCLK && !cclk_prev) begin
            ncclk++;
            sh = {sh[14:0], CSDI};
        end
        cclk_prev = CCLK;
        if (o == 36) begin
            chk("cclk_cnt", ncclk, 16);
            if (r == 3) chk("col_bits", {16'h0, sh}, 32'hA5C3);
        end

        if (frame_done) begin
            if (last_fd >= 0) chk("fd_period", cyc - last_fd, FRAME);
            last_fd = cyc;
        end
    endtask

    task automatic run_seg(input int n);
        last_fd   = -1;
        cclk_prev = 1'b0;
        for (int t = 0; t < n; t++) begin
            @(negedge clk32mhz);
            cyc++;
            check_cycle(t);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        dim_sel = 1'b0;
        fill_mem();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk32mhz);
            chk("rst_oeb",  32'(OEB), 1);
            chk("rst_outs", 32'({CSDI, CCLK, RSDI, RCLK, LE, fbi.fb_rd_en, frame_done}), 0);
            chk("rst_row",  32'(fbi.fb_row), 0);
        end
        reset_n = 1'b1;

        // Two full frames plus a row: walk, wrap and frame_done spacing.
        run_seg(2 * FRAME + P + 3);

        // New picture, dimmed, then a reset in the middle of row 7's column shift.
        reset_n = 1'b0;
        @(negedge clk32mhz);
        fill_mem();
        dim_sel = 1'b1;
        reset_n = 1'b1;
        run_seg(7 * P + 11);
        reset_n = 1'b0;
        @(negedge clk32mhz);
        cur_t = -1;
        chk("mid_oeb",  32'(OEB),  1);
        chk("mid_cclk", 32'(CCLK), 0);
        chk("mid_rd",   32'(fbi.fb_rd_en), 0);
        dim_sel = 1'($urandom_range(0, 1));
        reset_n = 1'b1;
        run_seg(FRAME + 2 * P);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/matrix_scanner.md
# matrix_scanner

Row-scan controller for the 16x16 LED matrix display in the pong design. Runs on `clk32mhz`. Every 16-bit row is fetched from the game's frame-buffer read port and shifted serially into the column driver. The one-hot row selector is then advanced, both drivers are latched, and the row is lit for a fixed dwell. It drives the RCLK/RSDI/OEB/CSDI/CCLK/LE pad signals, so the pong top level no longer builds matrix timing inline.

## Interface
- `SCREENTIMERWIDTH`, default 10: width of the dwell counter. Each row is lit for 2^SCREENTIMERWIDTH cycles. Legal range 2..16.
- `clk32mhz` in, 1: system clock, about 31.5 MHz.
- `reset_n` in, 1: reset, synchronous and active-low.
- `fb_rd_en` out, 1: frame-buffer read strobe, one cycle wide.
- `fb_row` out, 4: row address of the read. Held stable from the strobe until the next fetch.
- `fb_data` in, 16: row pixels, valid exactly 1 cycle after `fb_rd_en`. Bit 15 is column 15.
- `CSDI` out, 1: column serial data, 1 = pixel on.
- `CCLK` out, 1: column shift clock. Data is sampled on its rising edge.
- `RSDI` out, 1: row serial data, the one-hot seed.
- `RCLK` out, 1: row shift clock. Data is sampled on its rising edge.
- `LE` out, 1: latch enable for both drivers, one-cycle pulse.
- `OEB` out, 1: output enable bar. 1 = matrix dark.
- `frame_done` out, 1: one-cycle pulse on the last dwell cycle of row 15.

## Operation
- **Reset values** (reset_n = 0 at a clock edge): CSDI, CCLK, RSDI, RCLK, LE, fb_rd_en, frame_done = 0; OEB = 1; fb_row = 0; state = FETCH; row = 0; counters = 0.
- **FETCH** (1 cycle): fb_rd_en = 1, fb_row = row. Next state CAPTURE.
- **CAPTURE** (1 cycle): load fb_data into the 16-bit shift register. Next state SHIFT_COL, with bit index = 15.
- **SHIFT_COL** (32 cycles): 2 cycles per bit, MSB first.
  - Phase 0: CCLK = 0, CSDI = sr[15].
  - Phase 1: CCLK = 1, CSDI held, then shift sr left by one.
  - After bit 0's phase 1, next state SHIFT_ROW.
- **SHIFT_ROW** (2 cycles): RSDI = 1 if row == 0, else 0. RCLK = 0, then RCLK = 1.
- **LATCH** (1 cycle): LE = 1. Pulsed once per row; it latches the shifted row/column data into both drivers.
- **DISPLAY** (2^SCREENTIMERWIDTH cycles): OEB = 0 and the dwell counter increments.
  - On the terminal count, row = row + 1 (4-bit, wraps 15 -> 0) and next state is FETCH.
  - frame_done = 1 on the terminal cycle only when row == 15.
- **OEB outside DISPLAY**: OEB = 1 in every state other than DISPLAY, so shifting is never visible on the matrix.
- **Shift clocks**: CCLK and RCLK are 0 in every state except their own phase-1 cycles.
- **Reset mid-operation**: takes effect at the next edge from any state or phase. There is no partial-row completion; the next row shown is row 0.
- **fb_data outside CAPTURE**: ignored. Changes to the frame buffer mid-frame appear only at that row's next fetch.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Row period = 1 + 1 + 32 + 2 + 1 + 2^W = 37 + 2^W cycles.
- Frame period = 16 × (37 + 2^W) cycles. At W = 10 this is 16976 cycles, about 1.86 kHz at 31.5 MHz.
- After reset is released, the first fb_rd_en occurs in the first cycle with reset_n = 1.
- Row 0's LE occurs 36 cycles after that fb_rd_en; OEB goes low the cycle after LE.
- Read latency is fixed at 1. The bench model must return data on cycle N+1 for a strobe on cycle N.

## Configuration
- `MATRIX_DIM_EN` defined:
  - Adds input `dim`, 1 bit, sampled in the LATCH cycle.
  - If dim = 1, OEB = 0 only for the first 2^(SCREENTIMERWIDTH-2) DISPLAY cycles and is 1 for the rest. This is 25% duty.
  - Dwell length, row period and frame_done timing are unchanged.
- `MATRIX_DIM_EN` undefined: no `dim` port, and OEB = 0 for the whole of DISPLAY.

## Structure
- The shared package `pong_pkg` holds:
  - the state enum FETCH, CAPTURE, SHIFT_COL, SHIFT_ROW, LATCH, DISPLAY;
  - `MATRIX_N = 16`;
  - `MATRIX_ROW_W = 4`.
- One sub-module is natural: `matrix_col_shifter`, a 16-bit parallel-load, MSB-first PISO with load and shift strobes.
- The dwell counter, row counter and FSM stay in matrix_scanner.

## Test plan
Run at SCREENTIMERWIDTH = 2, giving a 41-cycle row and a 656-cycle frame.
- **Reset and first row**: hold reset_n = 0 for 3 cycles, then release.
  - During reset: OEB = 1 and every other output = 0.
  - First cycle after release: fb_rd_en = 1, fb_row = 0.
  - LE pulse 36 cycles after that strobe.
- **Column bit order**: fb_data = 16'hA5C3 for row 3. Bench samples CSDI on CCLK rising edges.
  - Must read 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - Exactly 16 CCLK rising edges per row.
- **Row walk and wrap**: RSDI = 1 at the RCLK rising edge for row 0 only.
  - fb_row sequence is 0..15, then 0.
  - frame_done pulses once every 656 cycles, coincident with the last OEB-low cycle of row 15.
- **Blanking**: across a full frame, OEB = 0 only during DISPLAY (4 cycles per row).
  - LE, CCLK and RCLK are never high while OEB = 0.
- **Reset mid-shift**: assert reset_n = 0 for 1 cycle during SHIFT_COL of row 7.
  - Next edge: OEB = 1 and CCLK = 0.
  - First cycle after release: fb_rd_en with fb_row = 0.
- **MATRIX_DIM_EN build**: dim = 1 gives OEB = 0 for exactly 1 cycle per row; dim = 0 gives 4 cycles.
  - Row period stays 41 cycles in both cases.
